// File: rtl/rggen_apb_register_file.sv
// APB slave register file with per-bit RW/RO masking, byte strobes and configurable wait states.
// Define RGGEN_APB_REGISTER_FILE_ERROR_EN to report unmapped or fully read-only writes via o_pslverr.
module rggen_apb_register_file #(
  parameter int                              DATA_WIDTH    = 32,
  parameter int                              ADDRESS_WIDTH = 16,
  parameter int                              NUM_REGS      = 4,
  parameter int                              WAIT_CYCLES   = 0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  INITIAL_VALUE = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RW_MASK       = '1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDRESS_WIDTH-1:0]         i_paddr,
  input  logic [2:0]                       i_pprot,
  input  logic                             i_psel,
  input  logic                             i_penable,
  input  logic                             i_pwrite,
  input  logic [DATA_WIDTH-1:0]            i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]          i_pstrb,
  output logic                             o_pready,
  output logic [DATA_WIDTH-1:0]            o_prdata,
  output logic                             o_pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   o_reg_value,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   i_hw_value,
  output logic [NUM_REGS-1:0]              o_write_pulse
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int LSB     = $clog2(STRB_W);
  localparam int IDX_W   = ADDRESS_WIDTH - LSB;
  localparam int CMP_W   = IDX_W + 32;
  localparam int TOTAL_W = NUM_REGS * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [TOTAL_W-1:0]    reg_q, reg_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic [NUM_REGS-1:0]   hit;
  logic                  mapped;
  logic                  err;
  logic                  resp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] byte_en;
  logic                  unused_sig;

  assign unused_sig = ^{i_pprot, i_paddr};
  assign resp       = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      ST_IDLE: begin
        if (i_psel && !i_penable) begin
          idx_d   = i_paddr[ADDRESS_WIDTH-1:LSB];
          wr_d    = i_pwrite;
          wdata_d = i_pwdata;
          strb_d  = i_pstrb;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_psel) begin
          state_d = ST_IDLE;
        end else if (i_penable) begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode and read mux: RO bits come straight from hardware.
  always_comb begin
    hit   = '0;
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (CMP_W'(idx_q) == CMP_W'(i)) begin
        hit[i] = 1'b1;
        rdata  = (reg_q[i*DATA_WIDTH +: DATA_WIDTH] & RW_MASK[i*DATA_WIDTH +: DATA_WIDTH]) |
                 (i_hw_value[i*DATA_WIDTH +: DATA_WIDTH] & ~RW_MASK[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
    mapped = |hit;
  end

`ifdef RGGEN_APB_REGISTER_FILE_ERROR_EN
  logic ro_hit;
  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit[i] && (RW_MASK[i*DATA_WIDTH +: DATA_WIDTH] == '0)) ro_hit = 1'b1;
    end
    err = !mapped || (wr_q && ro_hit);
  end
  assign o_pslverr = resp && !rst && err;
`else
  assign err       = 1'b0;
  assign o_pslverr = 1'b0;
`endif

  always_comb begin
    for (int b = 0; b < STRB_W; b++) byte_en[b*8 +: 8] = {8{strb_q[b]}};
  end

  // Commit happens on the edge closing RESP; the pulse lands with the new value.
  always_comb begin
    reg_d   = reg_q;
    pulse_d = '0;
    if (resp && wr_q && !err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit[i]) begin
          reg_d[i*DATA_WIDTH +: DATA_WIDTH] =
            (reg_q[i*DATA_WIDTH +: DATA_WIDTH] & ~(byte_en & RW_MASK[i*DATA_WIDTH +: DATA_WIDTH])) |
            (wdata_q & byte_en & RW_MASK[i*DATA_WIDTH +: DATA_WIDTH]);
          pulse_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      reg_q   <= INITIAL_VALUE;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      pulse_q <= pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    strb_q  <= strb_d;
  end

  assign o_pready      = resp && !rst;
  assign o_prdata      = (resp && !rst && !wr_q && !err) ? rdata : '0;
  assign o_reg_value   = reg_q;
  assign o_write_pulse = pulse_q;

endmodule

// File: doc/rggen_apb_register_file.md
RGGEN_APB_REGISTER_FILE -- requirements
Module: rggen_apb_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB data width, a multiple of 8 and at least 8.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16: APB byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 4: number of registers, from 1 to 256.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: extra ACCESS-phase wait cycles, from 0 to 15.
REQ-005 SHALL have parameter INITIAL_VALUE, default all zeros: packed NUM_REGS*DATA_WIDTH reset values, with register i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have parameter RW_MASK, default all ones: packed NUM_REGS*DATA_WIDTH; 1 means a read/write storage bit, 0 means a read-only hardware bit.
REQ-007 SHALL have these ports, in this order:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_paddr  in  ADDRESS_WIDTH  APB address.
- i_pprot  in  3  APB protection; ignored.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable.
- i_pwrite  in  1  1 = write, 0 = read.
- i_pwdata  in  DATA_WIDTH  write data.
- i_pstrb  in  DATA_WIDTH/8  byte write strobes.
- o_pready  out  1  transfer complete.
- o_prdata  out  DATA_WIDTH  read data.
- o_pslverr  out  1  transfer error.
- o_reg_value  out  NUM_REGS*DATA_WIDTH  current storage values.
- i_hw_value  in  NUM_REGS*DATA_WIDTH  values for read-only bits.
- o_write_pulse  out  NUM_REGS  one-cycle pulse per written register.

Function
REQ-008 Register index SHALL be i_paddr[ADDRESS_WIDTH-1 : log2(DATA_WIDTH/8)]; the address is mapped when index < NUM_REGS; low byte-offset bits are ignored.
REQ-009 FSM SHALL have states IDLE, WAIT and RESP.
REQ-010 IDLE: when i_psel=1 and i_penable=0 (SETUP), SHALL latch address, direction, data and strobes, load counter = WAIT_CYCLES and go to WAIT.
REQ-011 WAIT: while i_psel=1 and i_penable=1, SHALL decrement the counter if nonzero, and go to RESP when the counter is 0.
REQ-012 WAIT: if i_psel=0, SHALL abort to IDLE with no write and no o_pready.
REQ-013 RESP: SHALL drive o_pready=1 for exactly one cycle, together with valid o_prdata and o_pslverr, then return to IDLE.
REQ-014 o_pready latency SHALL be WAIT_CYCLES+2 cycles after the SETUP cycle; for example, WAIT_CYCLES=0 gives SETUP at T0 and o_pready at T2.
REQ-015 A write SHALL commit at the end of the RESP cycle and update only bits with the RW_MASK bit = 1 and the byte's i_pstrb bit = 1.
REQ-016 o_write_pulse[i] SHALL be 1 in the cycle after the commit, aligned with the updated o_reg_value, even when no bit actually changes.
REQ-017 Read data SHALL be (storage AND RW_MASK) OR (i_hw_value AND NOT RW_MASK), sampled in the RESP cycle.
REQ-018 o_prdata SHALL be 0 whenever o_pready=0 and for all writes.
REQ-019 A SETUP seen in RESP SHALL be ignored; a new transfer starts only from IDLE.
REQ-020 i_penable=1 without a prior SETUP SHALL be ignored.

Reset
REQ-021 While rst=1 the block SHALL enter IDLE with o_pready=0, o_prdata=0, o_pslverr=0, o_write_pulse=0, o_reg_value=INITIAL_VALUE and counter=0.
REQ-022 Reset asserted mid-transfer SHALL discard the transfer with no commit and no response.

Configuration
REQ-023 With RGGEN_APB_REGISTER_FILE_ERROR_EN defined, an unmapped access SHALL return o_pslverr=1 with o_pready, o_prdata=0 and no write.
REQ-024 With RGGEN_APB_REGISTER_FILE_ERROR_EN defined, a write to a register whose RW_MASK word is all zero SHALL also return o_pslverr=1, with no pulse.
REQ-025 Without RGGEN_APB_REGISTER_FILE_ERROR_EN, o_pslverr SHALL be tied 0, unmapped reads SHALL return 0, and unmapped writes SHALL be dropped silently.

Verification
REQ-026 Defaults: write 0xDEADBEEF, strobe 0xF, to 0x0004, then read 0x0004 -> o_pready at T2, o_prdata=0xDEADBEEF, o_write_pulse[1] high for one cycle.
REQ-027 Write 0xFFFFFFFF, strobe 0x5, to register 0 (initial value 0) -> readback 0x00FF00FF.
REQ-028 RW_MASK word 0 = 0x0000FFFF, i_hw_value word 0 = 0xABCD0000, write 0xFFFFFFFF -> read 0xABCDFFFF.
REQ-029 WAIT_CYCLES=3 -> o_pready at T5; i_psel dropped at T3 -> no o_pready and no write.
REQ-030 With the macro defined, access 0x0010 with NUM_REGS=4 -> o_pslverr=1, o_prdata=0; without the macro -> o_pslverr=0.
REQ-031 rst pulsed during WAIT of a write -> no write, o_reg_value=INITIAL_VALUE, FSM in IDLE.
